// File: rtl/leaf_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : leaf_stream_tx
// Brief    : Credit-based BFT leaf transmitter; packs a 32-bit vld/ack user
//            stream into 49-bit packets and honours resend and credit returns.
// Revision : 1.0 - initial release
// ============================================================================
module leaf_stream_tx #(
    parameter int PACKET_BITS        = 49,
    parameter int PAYLOAD_BITS       = 32,
    parameter int NUM_LEAF_BITS      = 4,
    parameter int NUM_PORT_BITS      = 4,
    parameter int NUM_ADDR_BITS      = 7,
    parameter int NUM_BRAM_ADDR_BITS = 8,
    parameter int SELF_LEAF          = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PACKET_BITS-1:0]        din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]        dout_leaf_interface2bft,
    input  logic                          resend,
    input  logic [NUM_LEAF_BITS-1:0]      cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0]      cfg_dst_port,
    input  logic [PAYLOAD_BITS-1:0]       din_user,
    input  logic                          vld_user,
    output logic                          ack_user,
    output logic [NUM_BRAM_ADDR_BITS:0]   credits
);

    localparam int c_vld_pos    = PACKET_BITS - 1;
    localparam int c_leaf_hi    = PACKET_BITS - 2;
    localparam int c_port_hi    = c_leaf_hi - NUM_LEAF_BITS;
    localparam int c_addr_hi    = c_port_hi - NUM_PORT_BITS;
    localparam int c_flag_pos   = PAYLOAD_BITS;
    localparam int c_freed_bits = 16;
    localparam int c_sum_bits   = 18;
    localparam logic [NUM_LEAF_BITS-1:0]    c_self_leaf   = NUM_LEAF_BITS'(SELF_LEAF);
    localparam logic [NUM_BRAM_ADDR_BITS:0] c_max_credits = (NUM_BRAM_ADDR_BITS+1)'(1 << NUM_BRAM_ADDR_BITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [PAYLOAD_BITS-1:0]         r_mem [2];
    logic                            r_wptr;
    logic                            r_rptr;
    logic [1:0]                      r_count;
    logic                            r_rdy;
    logic [NUM_ADDR_BITS-1:0]        r_seq;
    logic [NUM_BRAM_ADDR_BITS:0]     r_credits;
    logic [PACKET_BITS-1:0]          r_dout;

    logic                            w_empty;
    logic                            w_push;
    logic                            w_send;
    logic                            w_has_credit;
    logic                            w_credit_pkt;
    logic [c_freed_bits-1:0]         w_freed;
    logic [c_sum_bits-1:0]           w_sum;
    logic [PACKET_BITS-1:0]          w_pkt;
    logic                            w_unused_din;

    // Payload address field and upper credit bits carry nothing this block needs.
    assign w_unused_din = ^{din_leaf_bft2interface[c_addr_hi:c_flag_pos+1],
                            din_leaf_bft2interface[c_flag_pos-1:c_freed_bits]};

    assign w_empty      = (r_count == 2'd0);
    assign ack_user     = r_rdy & (r_count != 2'd2);
    assign w_push       = vld_user & ack_user;
    assign w_has_credit = (r_credits != '0);

    assign w_credit_pkt = din_leaf_bft2interface[c_vld_pos]
                        & din_leaf_bft2interface[c_flag_pos]
                        & (din_leaf_bft2interface[c_leaf_hi -: NUM_LEAF_BITS] == c_self_leaf)
                        & (din_leaf_bft2interface[c_port_hi -: NUM_PORT_BITS] == cfg_dst_port);
    assign w_freed      = w_credit_pkt ? din_leaf_bft2interface[c_freed_bits-1:0] : '0;
    assign w_sum        = c_sum_bits'(r_credits) + c_sum_bits'(w_freed) - c_sum_bits'(w_send);

    assign w_pkt = {1'b1, cfg_dst_leaf, cfg_dst_port, r_seq, 1'b0, r_mem[r_rptr]};

    // The send decision is made in the same cycle the FIFO head is visible,
    // which gives the two-cycle user-to-link latency.
    always_comb begin
        w_send      = 1'b0;
        w_state_nxt = r_state;
        if (!resend) begin
            case (r_state)
                S_IDLE, S_SEND, S_STALL: begin
                    if (!w_empty && w_has_credit) begin
                        w_send      = 1'b1;
                        w_state_nxt = S_SEND;
                    end else if (!w_empty) begin
                        w_state_nxt = S_STALL;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= 2'd0;
            r_rdy     <= 1'b0;
            r_seq     <= '0;
            r_credits <= c_max_credits;
            r_dout    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rdy   <= 1'b1;
            r_count <= r_count + 2'(w_push) - 2'(w_send);
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_send) begin
                r_rptr <= ~r_rptr;
                r_seq  <= r_seq + NUM_ADDR_BITS'(1);
            end
            r_credits <= (w_sum > c_sum_bits'(c_max_credits)) ? c_max_credits
                                                              : w_sum[NUM_BRAM_ADDR_BITS:0];
            // A deflected word is held verbatim, including an idle (all-zero) word.
            if (resend) begin
                r_dout <= r_dout;
            end else if (w_send) begin
                r_dout <= w_pkt;
            end else begin
                r_dout <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din_user;
        end
    end

    assign dout_leaf_interface2bft = r_dout;
    assign credits                 = r_credits;

endmodule
`default_nettype wire

// File: tb/tb_leaf_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_leaf_stream_tx
// Brief    : Scoreboard bench for leaf_stream_tx with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leaf_stream_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [48:0] din_bft;
    logic [48:0] dout;
    logic        resend;
    logic [3:0]  cfg_leaf;
    logic [3:0]  cfg_port;
    logic [31:0] din_user;
    logic        vld_user;
    logic        ack_user;
    logic [8:0]  credits;

    int          total = 0;
    int          bad   = 0;
    logic [48:0] exp_q[$];
    logic [48:0] mon_exp;
    logic        mon_en = 1'b0;
    logic [6:0]  exp_seq;
    logic [48:0] pkt5;

    always #5 clk = ~clk;

    leaf_stream_tx dut (
        .clk                     (clk),
        .reset                   (reset),
        .din_leaf_bft2interface  (din_bft),
        .dout_leaf_interface2bft (dout),
        .resend                  (resend),
        .cfg_dst_leaf            (cfg_leaf),
        .cfg_dst_port            (cfg_port),
        .din_user                (din_user),
        .vld_user                (vld_user),
        .ack_user                (ack_user),
        .credits                 (credits)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every valid word on the link must match the scoreboard head in order.
    always @(negedge clk) begin
        if (mon_en) begin
            if (dout[48]) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected packet: got %0h expected none", dout);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("packet", 64'(dout), 64'(mon_exp));
                end
            end else begin
                check("idle word", 64'(dout), 64'd0);
            end
        end
    end

    task automatic push_beat(input logic [31:0] data);
        int n;
        n = 0;
        @(negedge clk);
        din_user = data;
        vld_user = 1'b1;
        while (!ack_user && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ack_user) begin
            total++;
            bad++;
            $display("FAIL ack timeout: got ack=0 expected ack=1");
            vld_user = 1'b0;
            return;
        end
        exp_q.push_back({1'b1, cfg_leaf, cfg_port, exp_seq, 1'b0, data});
        exp_seq++;
        @(posedge clk);
    endtask

    task automatic stop_user();
        @(negedge clk);
        vld_user = 1'b0;
    endtask

    task automatic send_credit(input logic v, input logic [3:0] lf, input logic [3:0] pt,
                               input logic flag, input logic [15:0] freed);
        @(negedge clk);
        din_bft = {v, lf, pt, 7'd0, flag, 16'd0, freed};
        @(negedge clk);
        din_bft = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain remaining", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        din_bft  = '0;
        resend   = 1'b0;
        cfg_leaf = 4'h3;
        cfg_port = 4'h1;
        din_user = '0;
        vld_user = 1'b0;
        exp_seq  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset dout", 64'(dout), 64'd0);
        check("reset ack", 64'(ack_user), 64'd0);
        check("reset credits", 64'(credits), 64'd256);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single beat: exact packet and two-cycle latency.
        push_beat(32'hDEADBEEF);
        @(negedge clk);
        vld_user = 1'b0;
        check("latency early", 64'(dout), 64'd0);
        @(posedge clk);
        #1;
        check("first packet", 64'(dout), 64'h1_3100_DEAD_BEEF);
        check("credits after one", 64'(credits), 64'd255);
        drain();

        // Top credits back to 256, then exhaust them with a 256-beat stream.
        send_credit(1'b1, 4'h0, 4'h1, 1'b1, 16'd1);
        check("credits refill", 64'(credits), 64'd256);
        for (int i = 0; i < 256; i++) push_beat(32'hA000_0000 + 32'(i));
        push_beat(32'hB000_0000);
        push_beat(32'hB000_0001);
        stop_user();
        repeat (4) @(negedge clk);
        check("ack when full", 64'(ack_user), 64'd0);
        check("credits exhausted", 64'(credits), 64'd0);
        check("stalled beats held", 64'(exp_q.size()), 64'd2);

        // Credit release of 64 lets exactly 64 more packets out.
        send_credit(1'b1, 4'h0, 4'h1, 1'b1, 16'd64);
        for (int i = 0; i < 62; i++) push_beat(32'hC000_0000 + 32'(i));
        stop_user();
        drain();
        check("credits after 64", 64'(credits), 64'd0);

        // Malformed or misaddressed credit packets are ignored.
        send_credit(1'b1, 4'h2, 4'h1, 1'b1, 16'd5);
        check("wrong leaf", 64'(credits), 64'd0);
        send_credit(1'b1, 4'h0, 4'h2, 1'b1, 16'd5);
        check("wrong port", 64'(credits), 64'd0);
        send_credit(1'b1, 4'h0, 4'h1, 1'b0, 16'd5);
        check("no credit flag", 64'(credits), 64'd0);
        send_credit(1'b0, 4'h0, 4'h1, 1'b1, 16'd5);
        check("invalid packet", 64'(credits), 64'd0);
        send_credit(1'b1, 4'h0, 4'h1, 1'b1, 16'd5);
        check("good credit", 64'(credits), 64'd5);

        // Credit arrives while packets are being sent: 5 - 4 + 3.
        fork
            begin
                for (int i = 0; i < 4; i++) push_beat(32'hD000_0000 + 32'(i));
            end
            begin
                repeat (2) @(negedge clk);
                send_credit(1'b1, 4'h0, 4'h1, 1'b1, 16'd3);
            end
        join
        stop_user();
        drain();
        check("credit on send", 64'(credits), 64'd4);
        send_credit(1'b1, 4'h0, 4'h1, 1'b1, 16'd1000);
        check("credit saturate", 64'(credits), 64'd256);

        // Resend with an idle link keeps the link idle.
        @(negedge clk);
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
        check("resend idle", 64'(dout), 64'd0);

        // Reset in the middle of a stream drops everything in flight.
        push_beat(32'hE000_0000);
        push_beat(32'hE000_0001);
        push_beat(32'hE000_0002);
        #1;
        mon_en   = 1'b0;
        reset    = 1'b1;
        vld_user = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("mid reset dout", 64'(dout), 64'd0);
        check("mid reset credits", 64'(credits), 64'd256);
        check("mid reset ack", 64'(ack_user), 64'd0);
        @(negedge clk);
        reset   = 1'b0;
        exp_seq = '0;
        mon_en  = 1'b1;

        // Resend three cycles on seq 5; a waiting beat must not overtake it.
        for (int i = 0; i < 6; i++) push_beat(32'h5000_0000 + 32'(i));
        stop_user();
        pkt5 = {1'b1, 4'h3, 4'h1, 7'd5, 1'b0, 32'h5000_0005};
        begin
            int n;
            n = 0;
            while (dout !== pkt5 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check("seq5 seen", 64'(dout), 64'(pkt5));
        check("ack before resend", 64'(ack_user), 64'd1);
        repeat (3) exp_q.push_back(pkt5);
        resend   = 1'b1;
        din_user = 32'h5000_0006;
        vld_user = 1'b1;
        exp_q.push_back({1'b1, 4'h3, 4'h1, 7'd6, 1'b0, 32'h5000_0006});
        exp_seq++;
        @(posedge clk);
        @(negedge clk);
        vld_user = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resend = 1'b0;
        check("credits during resend", 64'(credits), 64'd250);
        drain();
        check("credits after resend", 64'(credits), 64'd249);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
